// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants for the FIFO control stage.
//   - Default geometry (DEPTH_DEF, AW_DEF) and count width (CW_DEF).
//   - 3-bit operation-state encodings used by fifo_ctrl and fifo_ns_logic.
package fifo_pkg;

  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned AW_DEF    = 3;
  // Count needs one extra bit to represent DEPTH itself.
  localparam int unsigned CW_DEF    = AW_DEF + 1;

  localparam logic [2:0] ST_INIT     = 3'd0;
  localparam logic [2:0] ST_NO_OP    = 3'd1;
  localparam logic [2:0] ST_WRITE    = 3'd2;
  localparam logic [2:0] ST_WR_ERROR = 3'd3;
  localparam logic [2:0] ST_READ     = 3'd4;
  localparam logic [2:0] ST_RD_ERROR = 3'd5;

endpackage

// File: rtl/fifo_ns_logic.sv
// fifo_ns_logic: combinational next-state / next-pointer / next-count decoder.
// Ports:
//   i_wr_en, i_rd_en   push / pop requests
//   i_count            current occupancy (AW+1 bits)
//   i_head, i_tail     current read / write pointers
//   i_rd_addr          current registered read-mux select
//   o_state            next operation state
//   o_head, o_tail     next pointers
//   o_count            next occupancy
//   o_rd_addr          next read-mux select
module fifo_ns_logic
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic          i_wr_en,
  input  logic          i_rd_en,
  input  logic [AW:0]   i_count,
  input  logic [AW-1:0] i_head,
  input  logic [AW-1:0] i_tail,
  input  logic [AW-1:0] i_rd_addr,
  output logic [2:0]    o_state,
  output logic [AW-1:0] o_head,
  output logic [AW-1:0] o_tail,
  output logic [AW:0]   o_count,
  output logic [AW-1:0] o_rd_addr
);

  localparam int unsigned CW = AW + 1;

  always_comb begin
    o_state   = ST_NO_OP;
    o_head    = i_head;
    o_tail    = i_tail;
    o_count   = i_count;
    o_rd_addr = i_rd_addr;
    // Simultaneous push and pop fall through to NO_OP without an error.
    if (i_wr_en && !i_rd_en) begin
      if (i_count < CW'(DEPTH)) begin
        o_state = ST_WRITE;
        o_tail  = i_tail + AW'(1);
        o_count = i_count + CW'(1);
      end else begin
        o_state = ST_WR_ERROR;
      end
    end else if (i_rd_en && !i_wr_en) begin
      if (i_count != '0) begin
        o_state   = ST_READ;
        o_rd_addr = i_head;
        o_head    = i_head + AW'(1);
        o_count   = i_count - CW'(1);
      end else begin
        o_state = ST_RD_ERROR;
      end
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: control stage of the 8 x 32-bit register-file FIFO.
// Holds head/tail pointers, occupancy count, read-mux select and the
// operation state; decodes handshake and status flags.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   wr_en, rd_en          push / pop requests
//   we, wr_addr           register-file write strobe and address (= tail)
//   rd_addr               registered read-mux select
//   full, empty           occupancy status
//   wr_ack, wr_err        previous-cycle push accepted / rejected
//   rd_ack, rd_err        previous-cycle pop accepted / rejected
//   data_count            occupancy, 0..DEPTH
//   almost_full/empty     only when FIFO_ALMOST_FLAGS_EN is defined
// Config macro: FIFO_ALMOST_FLAGS_EN adds the almost_full / almost_empty outputs.
// DEPTH must equal 2**AW so pointers wrap by natural overflow.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned AF_LEVEL = 7,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic          we,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic          full,
  output logic          empty,
  output logic          wr_ack,
  output logic          wr_err,
  output logic          rd_ack,
  output logic          rd_err,
  output logic [AW:0]   data_count
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic          almost_full,
  output logic          almost_empty
`endif
);

  localparam int unsigned CW = AW + 1;

  logic [2:0]    r_state;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_rd_addr;

  logic [2:0]    w_state_d;
  logic [AW-1:0] w_head_d;
  logic [AW-1:0] w_tail_d;
  logic [AW:0]   w_count_d;
  logic [AW-1:0] w_rd_addr_d;

  fifo_ns_logic #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ns_logic (
    .i_wr_en   (wr_en),
    .i_rd_en   (rd_en),
    .i_count   (r_count),
    .i_head    (r_head),
    .i_tail    (r_tail),
    .i_rd_addr (r_rd_addr),
    .o_state   (w_state_d),
    .o_head    (w_head_d),
    .o_tail    (w_tail_d),
    .o_count   (w_count_d),
    .o_rd_addr (w_rd_addr_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_INIT;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_rd_addr <= '0;
    end else begin
      r_state   <= w_state_d;
      r_head    <= w_head_d;
      r_tail    <= w_tail_d;
      r_count   <= w_count_d;
      r_rd_addr <= w_rd_addr_d;
    end
  end

  assign full       = (r_count == CW'(DEPTH));
  assign empty      = (r_count == '0);
  assign data_count = r_count;

  // Register file captures on the same edge that advances tail; gated off during reset.
  assign we      = wr_en & ~rd_en & ~full & ~reset;
  assign wr_addr = r_tail;
  assign rd_addr = r_rd_addr;

  assign wr_ack = (r_state == ST_WRITE);
  assign wr_err = (r_state == ST_WR_ERROR);
  assign rd_ack = (r_state == ST_READ);
  assign rd_err = (r_state == ST_RD_ERROR);

`ifdef FIFO_ALMOST_FLAGS_EN
  assign almost_full  = (r_count >= CW'(AF_LEVEL));
  assign almost_empty = (r_count <= CW'(AE_LEVEL));
`else
  logic w_unused_levels;
  assign w_unused_levels = ^{AF_LEVEL, AE_LEVEL};
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: self-checking bench for fifo_ctrl with a behavioural register
// file and a data scoreboard (queue filled on push, drained on rd_ack).
module tb_fifo_ctrl;
  import fifo_pkg::*;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       we;
  logic [2:0] wr_addr;
  logic [2:0] rd_addr;
  logic       full;
  logic       empty;
  logic       wr_ack;
  logic       wr_err;
  logic       rd_ack;
  logic       rd_err;
  logic [3:0] data_count;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic       almost_full;
  logic       almost_empty;
`endif

  fifo_ctrl u_dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .we         (we),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .data_count (data_count)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural register file driven by the DUT's strobe and address.
  logic [31:0] din = '0;
  logic [31:0] mem [8];
  always @(posedge clk) if (we) mem[wr_addr] <= din;

  logic [31:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int m_count = 0;
  int m_head  = 0;
  int m_tail  = 0;
  int m_rd_addr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "/count"}, 32'(data_count), 32'(m_count));
    check({tag, "/full"},  32'(full),  32'(m_count == 8));
    check({tag, "/empty"}, 32'(empty), 32'(m_count == 0));
    check({tag, "/rd_addr"}, 32'(rd_addr), 32'(m_rd_addr));
`ifdef FIFO_ALMOST_FLAGS_EN
    check({tag, "/afull"},  32'(almost_full),  32'(m_count >= 7));
    check({tag, "/aempty"}, 32'(almost_empty), 32'(m_count <= 1));
`endif
  endtask

  task automatic check_flags(input string tag, input bit wa, input bit we_, input bit ra,
                             input bit re);
    check({tag, "/wr_ack"}, 32'(wr_ack), 32'(wa));
    check({tag, "/wr_err"}, 32'(wr_err), 32'(we_));
    check({tag, "/rd_ack"}, 32'(rd_ack), 32'(ra));
    check({tag, "/rd_err"}, 32'(rd_err), 32'(re));
  endtask

  task automatic push(input logic [31:0] d);
    bit acc;
    acc   = (m_count < 8);
    din   = d;
    wr_en = 1'b1;
    rd_en = 1'b0;
    #1;
    check("push/we", 32'(we), 32'(acc));
    if (acc) begin
      check("push/wr_addr", 32'(wr_addr), 32'(m_tail));
      exp_q.push_back(d);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (acc) begin
      m_tail = (m_tail + 1) % 8;
      m_count++;
    end
    check_flags("push", acc, !acc, 1'b0, 1'b0);
    check_status("push");
  endtask

  task automatic pop();
    bit acc;
    acc   = (m_count > 0);
    wr_en = 1'b0;
    rd_en = 1'b1;
    #1;
    check("pop/we", 32'(we), 32'(0));
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    if (acc) begin
      m_rd_addr = m_head;
      m_head    = (m_head + 1) % 8;
      m_count--;
    end
    check_flags("pop", 1'b0, 1'b0, acc, !acc);
    if (rd_ack && exp_q.size() > 0) check("pop/data", mem[rd_addr], exp_q.pop_front());
    check_status("pop");
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    check_flags("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check_status("idle");
  endtask

  initial begin
    // Reset and idle.
    repeat (2) @(posedge clk);
    #1;
    check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check_status("rst");
    reset = 1'b0;
    repeat (3) idle();

    // Fill, overflow.
    for (int i = 1; i <= 8; i++) push(32'h1111_1111 * 32'(i));
    push(32'h9999_9999);

    // Drain, underflow.
    for (int i = 0; i < 8; i++) pop();
    pop();

    // Pointer wrap.
    for (int i = 0; i < 5; i++) push(32'hA000_0000 + 32'(i));
    for (int i = 0; i < 5; i++) pop();
    for (int i = 0; i < 6; i++) push(32'hB000_0000 + 32'(i));
    for (int i = 0; i < 6; i++) pop();

    // Simultaneous requests at count 3.
    for (int i = 0; i < 3; i++) push(32'hC000_0000 + 32'(i));
    wr_en = 1'b1;
    rd_en = 1'b1;
    #1;
    check("both/we", 32'(we), 32'(0));
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_flags("both", 1'b0, 1'b0, 1'b0, 1'b0);
    check_status("both");

    // Asynchronous reset mid-stream at count 4, with wr_ack currently high.
    push(32'hD000_0000);
    #2;
    wr_en = 1'b1;
    reset = 1'b1;
    #1;
    m_count = 0; m_head = 0; m_tail = 0; m_rd_addr = 0;
    exp_q.delete();
    check_flags("arst", 1'b0, 1'b0, 1'b0, 1'b0);
    check_status("arst");
    check("arst/we", 32'(we), 32'(0));
    @(posedge clk);
    #1;
    check_status("arst_hold");
    wr_en = 1'b0;
    reset = 1'b0;

    // Recovery after reset.
    push(32'hE000_0001);
    push(32'hE000_0002);
    pop();
    pop();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
